// File: rtl/project_pkg.sv
// Shared project types and helpers: pixel colour type, log2 helper and the
// priority encoder used by the layer compositor.
package project;

  // 12-bit RGB444 pixel as produced by the sprite/tile renderers.
  typedef logic [11:0] rgb_t;

  // Upper bound on compositor layers; prio_idx is sized for this many.
  localparam int MAX_LAYERS = 16;

  // Ceiling log2, never less than 1 so index ports always have a bit.
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

  // Index of the highest set bit; 0 when no bit is set.
  function automatic logic [3:0] prio_idx(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < MAX_LAYERS; i++) begin
      if (v[i]) begin
        r = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/video_compositor_vsync_edge.sv
// vsync rising-edge detector. One instance feeds both the config commit and
// the collision snapshot so the two always act on the same pixel cycle.
module vsync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsync,
  output logic o_rise
);

  logic vs_prev_q;

  // Remember last cycle's vsync level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_prev_q <= 1'b0;
    end else begin
      vs_prev_q <= i_vsync;
    end
  end

  // Combinational pulse in the cycle vsync is first seen high.
  assign o_rise = i_vsync & ~vs_prev_q;

endmodule

// File: rtl/video_compositor.sv
// N-layer priority compositor with double-buffered layer enables and
// background colour, a 2-stage pixel/sync pipeline and an optional per-frame
// collision report (enabled by defining COMPOSITOR_COLLISION_EN).
// Streaming only: there is no valid/ready handshake. Every input cycle is a
// pixel and produces exactly one output pixel two cycles later.
module video_compositor
  import project::*;
#(
  parameter int N_LAYERS = 4,
  parameter int LW       = clogb2(N_LAYERS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_hsync,
  input  logic                i_vsync,
  input  logic [N_LAYERS-1:0] i_req,
  input  rgb_t [N_LAYERS-1:0] i_vport,
  input  logic                i_cfg_wr,
  input  logic [N_LAYERS-1:0] i_cfg_en,
  input  rgb_t                i_cfg_bg,
  output logic                o_cfg_pending,
  output rgb_t                o_vport,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_hit,
  output logic [LW-1:0]       o_layer,
  output logic [N_LAYERS-1:0] o_collide,
  output logic                o_collide_valid
);

  logic vs_rise;

  vsync_edge u_vsync_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_vsync (i_vsync),
    .o_rise  (vs_rise)
  );

  // ---------------- double-buffered configuration ----------------
  logic [N_LAYERS-1:0] shadow_en_q, shadow_en_d;
  logic [N_LAYERS-1:0] active_en_q, active_en_d;
  rgb_t                shadow_bg_q, shadow_bg_d;
  rgb_t                active_bg_q, active_bg_d;
  logic                pending_q, pending_d;

  // Commit shadow on the vsync edge; a write in the same cycle lands in
  // shadow after the old shadow has been committed, so pending stays set.
  always_comb begin
    shadow_en_d = shadow_en_q;
    shadow_bg_d = shadow_bg_q;
    active_en_d = active_en_q;
    active_bg_d = active_bg_q;
    pending_d   = pending_q;
    if (vs_rise) begin
      active_en_d = shadow_en_q;
      active_bg_d = shadow_bg_q;
      pending_d   = 1'b0;
    end
    if (i_cfg_wr) begin
      shadow_en_d = i_cfg_en;
      shadow_bg_d = i_cfg_bg;
      pending_d   = 1'b1;
    end
  end

  // Configuration state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_en_q <= '1;
      active_en_q <= '1;
      shadow_bg_q <= '0;
      active_bg_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      shadow_en_q <= shadow_en_d;
      active_en_q <= active_en_d;
      shadow_bg_q <= shadow_bg_d;
      active_bg_q <= active_bg_d;
      pending_q   <= pending_d;
    end
  end

  assign o_cfg_pending = pending_q;

  // ---------------- layer selection ----------------
  // active_en_q still holds the old mask during the edge cycle, so a new
  // commit first affects the pixel arriving the cycle after the edge.
  logic [N_LAYERS-1:0] eff;
  logic [LW-1:0]       win;

  assign eff = i_req & active_en_q;
  assign win = LW'(prio_idx(16'(eff)));

  // ---------------- stage 1 ----------------
  logic    s1_hit_q;
  logic [LW-1:0] s1_win_q;
  rgb_t    s1_px_q;
  rgb_t    s1_bg_q;
  logic    s1_hs_q, s1_vs_q;

  // Capture winner, its colour and the background in force for this pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_hit_q <= 1'b0;
      s1_win_q <= '0;
      s1_px_q  <= '0;
      s1_bg_q  <= '0;
      s1_hs_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
    end else begin
      s1_hit_q <= |eff;
      s1_win_q <= win;
      s1_px_q  <= i_vport[win];
      s1_bg_q  <= active_bg_q;
      s1_hs_q  <= i_hsync;
      s1_vs_q  <= i_vsync;
    end
  end

  // ---------------- stage 2 ----------------
  rgb_t          s2_px_q;
  logic          s2_hit_q;
  logic [LW-1:0] s2_layer_q;
  logic          s2_hs_q, s2_vs_q;

  // Final colour mux and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_px_q    <= '0;
      s2_hit_q   <= 1'b0;
      s2_layer_q <= '0;
      s2_hs_q    <= 1'b0;
      s2_vs_q    <= 1'b0;
    end else begin
      s2_px_q    <= s1_hit_q ? s1_px_q : s1_bg_q;
      s2_hit_q   <= s1_hit_q;
      s2_layer_q <= s1_win_q;
      s2_hs_q    <= s1_hs_q;
      s2_vs_q    <= s1_vs_q;
    end
  end

  assign o_vport = s2_px_q;
  assign o_hit   = s2_hit_q;
  assign o_layer = s2_layer_q;
  assign o_hsync = s2_hs_q;
  assign o_vsync = s2_vs_q;

  // ---------------- collision report ----------------
`ifdef COMPOSITOR_COLLISION_EN
  logic [N_LAYERS-1:0] coll_now;
  logic [N_LAYERS-1:0] acc_q, acc_d;
  logic [N_LAYERS-1:0] collide_q, collide_d;
  logic                cvalid_q, cvalid_d;

  // A layer collides when it and at least one other layer are both visible.
  always_comb begin
    coll_now = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      coll_now[i] = eff[i] & (|(eff & ~(N_LAYERS'(1) << i)));
    end
  end

  // Snapshot the finished frame on the edge; the edge cycle's own
  // collisions seed the next frame.
  always_comb begin
    acc_d     = acc_q | coll_now;
    collide_d = collide_q;
    cvalid_d  = 1'b0;
    if (vs_rise) begin
      collide_d = acc_q;
      cvalid_d  = 1'b1;
      acc_d     = coll_now;
    end
  end

  // Collision state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q     <= '0;
      collide_q <= '0;
      cvalid_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      collide_q <= collide_d;
      cvalid_q  <= cvalid_d;
    end
  end

  assign o_collide       = collide_q;
  assign o_collide_valid = cvalid_q;
`else
  assign o_collide       = '0;
  assign o_collide_valid = 1'b0;
`endif

endmodule

// File: doc/video_compositor.md
# video_compositor

Parametrised N-layer priority compositor that replaces the fixed two-port arbiter between the sprite/tile renderers and the VGA output stage. Each cycle it selects the highest-index enabled layer asserting a request, falls back to a programmable background colour, and delays hsync/vsync to match its 2-stage pipeline. Layer enables and background are double-buffered and take effect only at frame boundaries. An optional per-frame collision report feeds game logic, e.g. pacman/ghost contact.

## Interface

Parameters:
- N_LAYERS, default 4: number of video layers; legal range 2..16.
- LW, default clogb2(N_LAYERS): width of the layer index.

Ports:
- i_clk  in  1  pixel clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_hsync, i_vsync  in  1 each  active-high syncs from the timing generator, aligned with layer inputs.
- i_req  in  N_LAYERS  per-layer opaque-pixel request.
- i_vport  in  rgb_t [N_LAYERS-1:0]  per-layer pixel colour.
- i_cfg_wr  in  1  one-cycle strobe; loads shadow config.
- i_cfg_en  in  N_LAYERS  shadow layer-enable mask.
- i_cfg_bg  in  rgb_t  shadow background colour.
- o_cfg_pending  out  1  shadow written but not yet committed.
- o_vport  out  rgb_t  composited pixel.
- o_hsync, o_vsync  out  1 each  delayed syncs.
- o_hit  out  1  some layer won this pixel.
- o_layer  out  LW  index of the winning layer; 0 when o_hit=0.
- o_collide  out  N_LAYERS  last frame's collision flags (COMPOSITOR_COLLISION_EN only).
- o_collide_valid  out  1  one-cycle pulse when o_collide updates (COMPOSITOR_COLLISION_EN only).

## Operation

- Effective request is eff = i_req & active_en.
- Winner is the highest set index of eff. o_vport = i_vport[winner]. If eff=0, o_vport = active_bg.
- Config:
  - i_cfg_wr loads the shadow registers and sets pending.
  - On the vsync rising edge (i_vsync=1 while the registered previous i_vsync=0), shadow is copied to active and pending clears.
  - If i_cfg_wr coincides with the edge, the old shadow commits, the new values land in shadow, and pending stays 1.
  - Commit applies to pixels entering stage 1 on the cycle after the edge.
- Collision:
  - Bit i of the accumulator is set when eff[i]=1 and any other bit of eff is also 1 in the same cycle.
  - On the vsync rising edge, the accumulator is copied to o_collide, o_collide_valid pulses, and the accumulator restarts from that cycle's collisions.
- Reset values:
  - o_vport, o_hsync, o_vsync, o_hit, o_layer, o_collide, o_collide_valid, o_cfg_pending: all 0.
  - Active and shadow enables: all ones. Active and shadow bg: 0.
  - Accumulator: 0. Registered previous vsync: 0.
- Reset mid-frame discards pipeline contents. The first vsync edge after reset reports only collisions seen since reset.

## Timing

- Latency is exactly 2 cycles, input to o_vport, o_hit, o_layer, o_hsync and o_vsync.
  - Stage 1 registers eff, the winner index and the syncs.
  - Stage 2 registers the muxed colour.
- Syncs traverse the same 2 registers, so pixel/sync alignment is preserved.
- o_cfg_pending rises the cycle after i_cfg_wr and falls the cycle after the committing vsync edge.
- o_collide and o_collide_valid change the cycle after the detected edge.
- The pipeline has no back-pressure. Every input cycle produces an output cycle 2 later.

## Configuration

- COMPOSITOR_COLLISION_EN defined: the accumulator is built, and o_collide/o_collide_valid behave as above.
- Not defined: no accumulator; both ports are tied to 0.
- Compositing and config behaviour are identical either way.

## Structure

- Package `project`:
  - Existing: rgb_t, clogb2.
  - Add: MAX_LAYERS=16, and the function `project::prio_idx(logic [15:0]) -> logic [3:0]` (highest set bit, 0 if none).
- Sub-module `vsync_edge`: registers vsync and outputs a one-cycle rising-edge pulse. It is shared by the config commit and the collision snapshot so both act on the same cycle.

## Test plan

- N_LAYERS=4, i_req=4'b0101, all enabled, i_vport[2]=0x0F0 → 2 cycles later o_vport=0x0F0, o_layer=2, o_hit=1; syncs delayed 2 cycles.
- i_req=0, bg committed as 0x123 → o_vport=0x123, o_hit=0, o_layer=0.
- i_cfg_wr with en=4'b1011 mid-frame → old mask applies until the vsync edge; o_cfg_pending=1 until then; afterwards i_req=4'b0100 gives background.
- i_cfg_wr on the exact vsync-edge cycle → the previous shadow commits and o_cfg_pending stays 1 until the next edge.
- Layers 1 and 3 both requesting for one pixel, then vsync → o_collide=4'b1010 with a single-cycle o_collide_valid. Next frame with no overlap → o_collide=0.
- Assert i_rst mid-frame with requests active → all outputs 0 the following cycle, enables all ones, o_cfg_pending=0.
